// File: rtl/gates_using_mux.sv
// Mux-based reference for the six two-input gates, with a registered copy
// of the results for synchronous consumers.

module gates_using_mux_mux2 (
    input  logic sel_i,
    input  logic d0_i,
    input  logic d1_i,
    output logic y_o
);

    // An unknown select yields X rather than silently picking a leg.
    always_comb begin
        case (sel_i)
            1'b0:    y_o = d0_i;
            1'b1:    y_o = d1_i;
            default: y_o = 1'bx;
        endcase
    end

endmodule

module gates_using_mux (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a,
    input  logic       b,
    output logic       yand,
    output logic       yor,
    output logic       ynand,
    output logic       ynor,
    output logic       yxor,
    output logic       yxnor,
    output logic [5:0] gates_q
);

    logic b_n;
    logic [5:0] result_d;
    logic [5:0] result_q;

    gates_using_mux_mux2 u_inv_b (
        .sel_i (b),
        .d0_i  (1'b1),
        .d1_i  (1'b0),
        .y_o   (b_n)
    );

    gates_using_mux_mux2 u_and (
        .sel_i (a),
        .d0_i  (1'b0),
        .d1_i  (b),
        .y_o   (yand)
    );

    gates_using_mux_mux2 u_or (
        .sel_i (a),
        .d0_i  (b),
        .d1_i  (1'b1),
        .y_o   (yor)
    );

    gates_using_mux_mux2 u_nand (
        .sel_i (a),
        .d0_i  (1'b1),
        .d1_i  (b_n),
        .y_o   (ynand)
    );

    gates_using_mux_mux2 u_nor (
        .sel_i (a),
        .d0_i  (b_n),
        .d1_i  (1'b0),
        .y_o   (ynor)
    );

    gates_using_mux_mux2 u_xor (
        .sel_i (a),
        .d0_i  (b),
        .d1_i  (b_n),
        .y_o   (yxor)
    );

    gates_using_mux_mux2 u_xnor (
        .sel_i (a),
        .d0_i  (b_n),
        .d1_i  (b),
        .y_o   (yxnor)
    );

    assign result_d = {yxnor, yxor, ynor, ynand, yor, yand};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 6'b000000;
        end else begin
            result_q <= result_d;
        end
    end

    assign gates_q = result_q;

endmodule

// File: tb/tb_gates_using_mux.sv
// Self-checking bench for gates_using_mux against a behavioural gate model.

module tb_gates_using_mux;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       yand;
    logic       yor;
    logic       ynand;
    logic       ynor;
    logic       yxor;
    logic       yxnor;
    logic [5:0] gates_q;

    int total;
    int bad;
    logic [5:0] exp_q[$];

    gates_using_mux dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .yand    (yand),
        .yor     (yor),
        .ynand   (ynand),
        .ynor    (ynor),
        .yxor    (yxor),
        .yxnor   (yxnor),
        .gates_q (gates_q)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference: bit order {xnor, xor, nor, nand, or, and}
    function automatic logic [5:0] model(input logic ia, input logic ib);
        int s;
        logic [5:0] r;
        s = int'(ia) + int'(ib);
        r[0] = (s == 2);
        r[1] = (s >= 1);
        r[2] = !(s == 2);
        r[3] = (s == 0);
        r[4] = (s == 1);
        r[5] = (s != 1);
        return r;
    endfunction

    function automatic logic [5:0] comb_out();
        return {yxnor, yxor, ynor, ynand, yor, yand};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a = 1'b0;
        b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (gates_q !== 6'b000000) begin
            bad++;
            $display("FAIL reset_gates_q: got %b want %b", gates_q, 6'b000000);
        end
        total++;
        if (comb_out() !== model(1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_comb: got %b want %b", comb_out(), model(1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        for (int i = 0; i < 4; i++) begin
            a = i[1];
            b = i[0];
            #10;
            total++;
            if (comb_out() !== model(a, b)) begin
                bad++;
                $display("FAIL truth_table ab=%b%b: got %b want %b", a, b, comb_out(), model(a, b));
            end
        end
    endtask

    task automatic test_repeated();
        logic [1:0] vec [5];
        vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b01; vec[3] = 2'b11; vec[4] = 2'b01;
        for (int i = 0; i < 5; i++) begin
            a = vec[i][1];
            b = vec[i][0];
            #10;
            total++;
            if (comb_out() !== model(a, b)) begin
                bad++;
                $display("FAIL repeated[%0d] ab=%b%b: got %b want %b", i, a, b, comb_out(), model(a, b));
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        a = 1'b1;
        b = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (gates_q !== 6'b100011) begin
            bad++;
            $display("FAIL registered_11: got %b want %b", gates_q, 6'b100011);
        end
        @(negedge clk);
        a = 1'b0;
        b = 1'b0;
        #1;
        total++;
        if (gates_q !== 6'b100011) begin
            bad++;
            $display("FAIL registered_hold: got %b want %b", gates_q, 6'b100011);
        end
        @(posedge clk);
        #1;
        total++;
        if (gates_q !== 6'b101100) begin
            bad++;
            $display("FAIL registered_00: got %b want %b", gates_q, 6'b101100);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 1'b0;
        b = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (gates_q !== model(1'b0, 1'b1)) begin
            bad++;
            $display("FAIL async_preload: got %b want %b", gates_q, model(1'b0, 1'b1));
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (gates_q !== 6'b000000) begin
            bad++;
            $display("FAIL async_clear: got %b want %b", gates_q, 6'b000000);
        end
        total++;
        if (yor !== 1'b1 || yxor !== 1'b1) begin
            bad++;
            $display("FAIL async_comb: got yor=%b yxor=%b want yor=1 yxor=1", yor, yxor);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (gates_q !== model(1'b0, 1'b1)) begin
            bad++;
            $display("FAIL async_reload: got %b want %b", gates_q, model(1'b0, 1'b1));
        end
    endtask

    task automatic test_reset_held();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (comb_out() !== model(a, b)) begin
                bad++;
                $display("FAIL held_comb[%0d]: got %b want %b", i, comb_out(), model(a, b));
            end
            @(posedge clk);
            #1;
            total++;
            if (gates_q !== 6'b000000) begin
                bad++;
                $display("FAIL held_gates_q[%0d]: got %b want %b", i, gates_q, 6'b000000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp;
        exp_q.delete();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a = 1'($urandom);
            b = 1'($urandom);
            exp_q.push_back(model(a, b));
            #1;
            total++;
            if (comb_out() !== model(a, b)) begin
                bad++;
                $display("FAIL b2b_comb[%0d]: got %b want %b", i, comb_out(), model(a, b));
            end
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            total++;
            if (gates_q !== exp) begin
                bad++;
                $display("FAIL b2b_gates_q[%0d]: got %b want %b", i, gates_q, exp);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_truth_table();
        test_repeated();
        test_registered();
        test_async_reset();
        test_reset_held();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gates_using_mux.md
Name: gates_using_mux

Overview:
- Two-input universal-gate block that produces AND, OR, NAND, NOR, XOR and XNOR of inputs a and b.
- Every function is built exclusively from 2:1 multiplexer primitives.
- The six results are driven combinationally on individual outputs.
- The same six results are also captured into a registered 6-bit bus for synchronous consumers.
- Sits in the combinational-library area as the mux-based gate reference.

Parameters:
none

Ports:
- clk  input  1  clock for the registered result bus (rising edge)
- rst_n  input  1  asynchronous, active-low reset; clears the registered bus
- a  input  1  operand A
- b  input  1  operand B
- yand  output  1  a AND b (combinational)
- yor  output  1  a OR b (combinational)
- ynand  output  1  NOT(a AND b) (combinational)
- ynor  output  1  NOT(a OR b) (combinational)
- yxor  output  1  a XOR b (combinational)
- yxnor  output  1  NOT(a XOR b) (combinational)
- gates_q  output  6  registered results: [0]=and, [1]=or, [2]=nand, [3]=nor, [4]=xor, [5]=xnor

Behaviour:
- Mux primitive: y = sel ? d1 : d0. All gate logic is built from instances of this primitive only; no &, |, ^ or ~ operators in the gate paths.
- Inverter: mux with sel=input, d0=1, d1=0.
- yand: mux sel=a, d0=0, d1=b.
- yor: mux sel=a, d0=b, d1=1.
- ynand: mux sel=a, d0=1, d1=~b (~b from the mux inverter).
- ynor: mux sel=a, d0=~b, d1=0.
- yxor: mux sel=a, d0=b, d1=~b.
- yxnor: mux sel=a, d0=~b, d1=b.
- Combinational outputs are pure functions of a and b. They are independent of clk and rst_n, including during reset, and have zero-cycle latency.
- Truth table (a b -> and or nand nor xor xnor):
  - 00 -> 0 0 1 1 0 1
  - 01 -> 0 1 1 0 1 0
  - 10 -> 0 1 1 0 1 0
  - 11 -> 1 1 0 0 0 1
- gates_q: on each rising clk edge with rst_n=1, loads {yxnor, yxor, ynor, ynand, yor, yand}. One-cycle latency from an input change to gates_q.
- Reset: rst_n=0 forces gates_q=6'b000000 immediately, without waiting for a clock edge, and holds it while low.
- First rising edge after rst_n deasserts loads the current results.
- Reset asserted mid-operation clears gates_q at once; combinational outputs are unaffected.
- X/Z on a or b: the mux primitive must not be written to resolve them optimistically. An X operand propagates to the outputs it affects.

Test Plan:
- Exhaustive combinational check: drive a,b = 00, 01, 10, 11 and wait 10 time units each -> outputs match the truth table rows exactly (e.g. 01 -> 0 1 1 0 1 0).
- Repeated-vector check: drive 00, 01, 01, 11, 01 -> rows 001101, 011010, 011010, 110001, 011010 (and, or, nand, nor, xor, xnor).
- Registered path: with rst_n=1, set a=1, b=1 before a clk edge -> gates_q=6'b100011 after that edge. Change to a=0, b=0 -> gates_q stays 100011 until the next edge, then becomes 6'b101100.
- Async reset: with gates_q=6'b011010 (a=0, b=1), drop rst_n mid-cycle -> gates_q=0 immediately, while yor=1 and yxor=1 persist. Raise rst_n -> the next edge reloads 011010.
- Reset held: keep rst_n=0 across 3 clk edges while toggling a and b -> gates_q remains 0 and the combinational outputs track the inputs every time.
- Structural check: lint or inspection confirms only mux-primitive instances drive the six gate outputs.
